mem_port_arb: RTL and testbench

- Round-robin arbiter that shares one memory port between N_REQ requesters (matmul engines, DMA, host).
- Each requester owns the port for a burst of up to MAX_BURST accepted accesses.
- Reads are tagged in an in-order outstanding-read FIFO, so each returned data beat is routed to the requester that issued the read.
- Sits between the compute engines and the single memory interface.

---
 rtl/mem_port_arb.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_port_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// mem_port_arb: round-robin burst arbiter sharing one memory port between N_REQ requesters,
// with an in-order read-tag FIFO for routing returned data. Optional stats: MEM_ARB_STATS_EN.
module mem_port_arb #(
  parameter int N_REQ     = 2,
  parameter int MEM_AW    = 16,
  parameter int MEM_DW    = 32,
  parameter int OUTST     = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        write,
  input  logic [N_REQ*MEM_AW-1:0] addr,
  input  logic [N_REQ*MEM_DW-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rd_vld,
  output logic [MEM_DW-1:0]       rd_data,
  output logic                    mem_req,
  output logic                    mem_write,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic [MEM_DW-1:0]       mem_wdata,
  input  logic                    mem_rdata_vld,
  input  logic [MEM_DW-1:0]       mem_rdata,
  output logic                    err
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic [$clog2(N_REQ)-1:0] stat_sel,
  input  logic                     stat_clr,
  output logic [15:0]              stat_gnt,
  output logic [15:0]              stat_wait
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int CW = $clog2(OUTST + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t          state_r, state_nx_s;
  logic [IW-1:0]   owner_r, owner_nx_s, rr_r, rr_nx_s, nxt_owner_s;
  logic [BW-1:0]   burst_r, burst_nx_s;
  logic [IW-1:0]   tag_mem_r [OUTST];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            pop_s, push_s, can_tag_s, gnt_any_s;
  logic [IW-1:0]   gnt_idx_s;
  logic [N_REQ-1:0] elig_s, head_oh_s;
  logic [IW:0]     pick_idle_s, pick_rel_s;

  // First eligible requester scanning upward from start; MSB flags a hit.
  function automatic logic [IW:0] pick(input logic [N_REQ-1:0] elig, input logic [IW-1:0] start);
    logic [IW:0]   res;
    logic [IW-1:0] idx;
    int            k;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k   = int'(start) + i;
      k   = (k >= N_REQ) ? k - N_REQ : k;
      idx = IW'(k);
      res = elig[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  assign pop_s       = mem_rdata_vld && (count_r != '0);
  assign can_tag_s   = (count_r != CW'(OUTST)) || pop_s;
  assign nxt_owner_s = (owner_r == IW'(N_REQ - 1)) ? '0 : owner_r + 1'b1;
  assign pick_idle_s = pick(elig_s, rr_r);
  assign pick_rel_s  = pick(elig_s, nxt_owner_s);
  assign push_s      = gnt_any_s && !write[gnt_idx_s];

  // Eligibility, grant one-hot and FIFO head decode.
  always_comb begin
    elig_s    = '0;
    gnt       = '0;
    head_oh_s = '0;
    for (int r = 0; r < N_REQ; r++) begin
      elig_s[r]    = req[r] && (write[r] || can_tag_s);
      gnt[r]       = gnt_any_s && (gnt_idx_s == IW'(r));
      head_oh_s[r] = (tag_mem_r[rd_ptr_r] == IW'(r));
    end
  end

  // Arbitration FSM next-state and combinational grant.
  always_comb begin
    state_nx_s = state_r;
    owner_nx_s = owner_r;
    rr_nx_s    = rr_r;
    burst_nx_s = burst_r;
    gnt_any_s  = 1'b0;
    gnt_idx_s  = owner_r;
    if (rst) begin
      gnt_any_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_idle_s[IW]) begin
            gnt_any_s  = 1'b1;
            gnt_idx_s  = pick_idle_s[IW-1:0];
            owner_nx_s = pick_idle_s[IW-1:0];
            state_nx_s = OWN;
            burst_nx_s = BW'(1);
          end else begin
            state_nx_s = IDLE;
          end
        end
        OWN: begin
          if (!req[owner_r]) begin
            // Owner dropped: rotate, then re-arbitrate in the same cycle.
            rr_nx_s = nxt_owner_s;
            if (pick_rel_s[IW]) begin
              gnt_any_s  = 1'b1;
              gnt_idx_s  = pick_rel_s[IW-1:0];
              owner_nx_s = pick_rel_s[IW-1:0];
              burst_nx_s = BW'(1);
            end else begin
              state_nx_s = IDLE;
              burst_nx_s = '0;
            end
          end else if (elig_s[owner_r]) begin
            gnt_any_s = 1'b1;
            if ((burst_r + BW'(1)) == BW'(MAX_BURST)) begin
              state_nx_s = IDLE;
              rr_nx_s    = nxt_owner_s;
              burst_nx_s = '0;
            end else begin
              burst_nx_s = burst_r + BW'(1);
            end
          end else begin
            burst_nx_s = burst_r;
          end
        end
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // FSM state and registered memory-port drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      owner_r   <= '0;
      rr_r      <= '0;
      burst_r   <= '0;
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_r   <= state_nx_s;
      owner_r   <= owner_nx_s;
      rr_r      <= rr_nx_s;
      burst_r   <= burst_nx_s;
      mem_req   <= gnt_any_s;
      mem_write <= gnt_any_s && write[gnt_idx_s];
      if (gnt_any_s) begin
        mem_addr  <= addr[gnt_idx_s*MEM_AW +: MEM_AW];
        mem_wdata <= wdata[gnt_idx_s*MEM_DW +: MEM_DW];
      end
    end
  end

  // Read-tag FIFO, read-data routing and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUTST; i++) tag_mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      rd_vld   <= '0;
      rd_data  <= '0;
      err      <= 1'b0;
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= gnt_idx_s;
        wr_ptr_r            <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
        rd_data  <= mem_rdata;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      rd_vld <= pop_s ? head_oh_s : '0;
      if (mem_rdata_vld && (count_r == '0)) err <= 1'b1;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_gnt_r  [N_REQ];
  logic [15:0] stat_wait_r [N_REQ];

  // Saturating per-requester grant and wait counters; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N_REQ; r++) begin
        stat_gnt_r[r]  <= 16'd0;
        stat_wait_r[r] <= 16'd0;
      end
    end else begin
      for (int r = 0; r < N_REQ; r++) begin
        if (stat_clr) begin
          stat_gnt_r[r]  <= 16'd0;
          stat_wait_r[r] <= 16'd0;
        end else begin
          if (gnt[r] && (stat_gnt_r[r] != 16'hFFFF)) stat_gnt_r[r] <= stat_gnt_r[r] + 16'd1;
          if (req[r] && !gnt[r] && (stat_wait_r[r] != 16'hFFFF)) stat_wait_r[r] <= stat_wait_r[r] + 16'd1;
        end
      end
    end
  end

  assign stat_gnt  = stat_gnt_r[stat_sel];
  assign stat_wait = stat_wait_r[stat_sel];
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed self-checking bench for mem_port_arb (N_REQ=2, default parameters).
module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0, write = '0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  gnt, rd_vld;
  logic [31:0] rd_data, mem_wdata, mem_rdata = '0;
  logic        mem_req, mem_write, mem_rdata_vld = 1'b0, err;
  logic [15:0] mem_addr;
`ifdef MEM_ARB_STATS_EN
  logic        stat_sel = 1'b0, stat_clr = 1'b0;
  logic [15:0] stat_gnt, stat_wait, g_sum;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mem_port_arb dut (
    .clk(clk), .rst(rst), .req(req), .write(write), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rd_vld(rd_vld), .rd_data(rd_data), .mem_req(mem_req),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata), .err(err)
`ifdef MEM_ARB_STATS_EN
    , .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_gnt(stat_gnt), .stat_wait(stat_wait)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [15:0] a0,
                       input logic [15:0] a1, input logic [31:0] d0, input logic v,
                       input logic [31:0] rdat);
    req = r; write = w; addr = {a1, a0}; wdata = {32'h0, d0};
    mem_rdata_vld = v; mem_rdata = rdat;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state with requests pending.
    tick();
    drive(2'b11, 2'b11, 16'h1, 16'h2, 32'h3, 1'b0, 32'h0);
    check_eq("rst_gnt", gnt, 2'b00);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_write", mem_write, 1'b0);
    check_eq("rst_rd_vld", rd_vld, 2'b00);
    check_eq("rst_rd_data", rd_data, 32'h0);
    check_eq("rst_err", err, 1'b0);
    do_reset();

    // Single-requester write burst.
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 2'b01, 16'(16'h0010 + i), 16'h0, 32'(i + 1), 1'b0, 32'h0);
      check_eq("wr_gnt", gnt, 2'b01);
      if (i > 0) begin
        check_eq("wr_mem_req", mem_req, 1'b1);
        check_eq("wr_mem_write", mem_write, 1'b1);
        check_eq("wr_mem_addr", mem_addr, 16'(16'h0010 + i - 1));
        check_eq("wr_mem_wdata", mem_wdata, 32'(i));
      end
      tick();
    end
    drive(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
    check_eq("wr_gnt_end", gnt, 2'b00);
    check_eq("wr_last_req", mem_req, 1'b1);
    check_eq("wr_last_addr", mem_addr, 16'h0013);
    check_eq("wr_last_data", mem_wdata, 32'h4);
    tick();
    check_eq("wr_req_drop", mem_req, 1'b0);

    // Two continuous requesters rotate in blocks of MAX_BURST.
    do_reset();
    for (int c = 0; c < 48; c++) begin
      drive(2'b11, 2'b11, 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
      check_eq("rr_gnt", gnt, (((c / 8) % 2) == 0) ? 2'b01 : 2'b10);
      tick();
    end

    // Read stall on full tag FIFO; lock held against r1.
    do_reset();
    for (int c = 0; c < 13; c++) begin
      drive({1'b1, (c < 12) ? 1'b1 : 1'b0}, 2'b10, 16'(16'h0100 + c), 16'h0200, 32'h0,
            (c == 11) ? 1'b1 : 1'b0, 32'h55);
      if (c < 4)       check_eq("stall_gnt_fill", gnt, 2'b01);
      else if (c < 11) check_eq("stall_gnt_block", gnt, 2'b00);
      else if (c == 11) check_eq("stall_gnt_pop", gnt, 2'b01);
      else begin
        check_eq("stall_gnt_r1", gnt, 2'b10);
        check_eq("stall_rd_vld", rd_vld, 2'b01);
        check_eq("stall_rd_data", rd_data, 32'h55);
      end
      if (c == 1) begin
        check_eq("stall_mem_write", mem_write, 1'b0);
        check_eq("stall_mem_addr", mem_addr, 16'h0100);
      end
      tick();
    end

    // Interleaved reads routed back in order.
    do_reset();
    drive(2'b01, 2'b00, 16'h0020, 16'h0, 32'h0, 1'b0, 32'h0);
    check_eq("il_gnt0", gnt, 2'b01);
    tick();
    drive(2'b10, 2'b00, 16'h0, 16'h0040, 32'h0, 1'b0, 32'h0);
    check_eq("il_gnt1", gnt, 2'b10);
    check_eq("il_addr0", mem_addr, 16'h0020);
    tick();
    drive(2'b01, 2'b00, 16'h0021, 16'h0, 32'h0, 1'b0, 32'h0);
    check_eq("il_gnt2", gnt, 2'b01);
    check_eq("il_addr1", mem_addr, 16'h0040);
    tick();
    drive(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
    check_eq("il_addr2", mem_addr, 16'h0021);
    check_eq("il_rd_mode", mem_write, 1'b0);
    tick();
    drive(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 1'b1, 32'hA);
    tick();
    drive(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 1'b1, 32'hB);
    check_eq("il_vld_a", rd_vld, 2'b01);
    check_eq("il_data_a", rd_data, 32'hA);
    tick();
    drive(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 1'b1, 32'hC);
    check_eq("il_vld_b", rd_vld, 2'b10);
    check_eq("il_data_b", rd_data, 32'hB);
    tick();
    drive(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
    check_eq("il_vld_c", rd_vld, 2'b01);
    check_eq("il_data_c", rd_data, 32'hC);
    tick();
    check_eq("il_vld_idle", rd_vld, 2'b00);
    check_eq("il_data_hold", rd_data, 32'hC);
    check_eq("il_err", err, 1'b0);

    // Reset with reads outstanding: late returns are errors.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(2'b01, 2'b00, 16'(16'h0030 + c), 16'h0, 32'h0, 1'b0, 32'h0);
      check_eq("mr_gnt", gnt, 2'b01);
      tick();
    end
    rst = 1'b1;
    drive(2'b01, 2'b00, 16'h0033, 16'h0, 32'h0, 1'b0, 32'h0);
    check_eq("mr_gnt_rst", gnt, 2'b00);
    check_eq("mr_mem_req_rst", mem_req, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    drive(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
    check_eq("mr_err_clear", err, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 1'b1, 32'(32'hA0 + k));
      tick();
      check_eq("mr_no_vld", rd_vld, 2'b00);
    end
    drive(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
    check_eq("mr_err_set", err, 1'b1);
    check_eq("mr_rd_data", rd_data, 32'h0);

`ifdef MEM_ARB_STATS_EN
    // Grant and wait counters over 20 contended cycles, then clear.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(2'b11, 2'b11, 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
      tick();
    end
    drive(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
    stat_sel = 1'b0;
    #1;
    check_eq("st_gnt0", stat_gnt, 16'd12);
    check_eq("st_wait0", stat_wait, 16'd8);
    g_sum = stat_gnt;
    stat_sel = 1'b1;
    #1;
    check_eq("st_gnt1", stat_gnt, 16'd8);
    check_eq("st_wait1", stat_wait, 16'd12);
    check_eq("st_gnt_sum", 16'(g_sum + stat_gnt), 16'd20);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    #1;
    check_eq("st_clr_gnt1", stat_gnt, 16'd0);
    check_eq("st_clr_wait1", stat_wait, 16'd0);
    stat_sel = 1'b0;
    #1;
    check_eq("st_clr_gnt0", stat_gnt, 16'd0);
    check_eq("st_clr_wait0", stat_wait, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
